// File: rtl/bsg_link_pearl_prbs_tester.sv
// ----------------------------------------------------------------------------
// bsg_link_pearl_prbs_tester
//
// Core-side PRBS traffic generator and checker for the DDR link pearl. The TX
// side drives a PRBS stream into the pearl core uplink. The RX side consumes
// the pearl core downlink and compares it against an identical PRBS. It is
// used for link bring-up, delay-line sweeps and loopback BIST.
//
// Ports
//   clk_i, reset_i        core clock, asynchronous active-high reset
//   start_i, num_words_i  begin a run of num_words_i words (IDLE/DONE only)
//   data_o, v_o           TX word/valid       -> pearl core_data_i / core_v_i
//   ready_and_i           TX ready            <- pearl core_ready_and_o
//   data_i, v_i           RX word/valid       <- pearl core_data_o / core_v_o
//   yumi_o                RX consume          -> pearl core_yumi_i
//   busy_o, done_o        run in progress / run finished
//   timeout_o             run aborted by RX idle timeout (sticky per run)
//   err_cnt_o             mismatched RX words (saturating)
//   first_err_idx_o       RX index of the first mismatch
//   tx_cnt_o, rx_cnt_o    TX / RX handshakes this run
// ----------------------------------------------------------------------------
module bsg_link_pearl_prbs_tester #(
    parameter int          width_p       = 64,
    parameter int          count_width_p = 32,
    parameter logic [31:0] seed_p        = 32'h1,
    parameter int          timeout_p     = 1024
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     start_i,
    input  logic [count_width_p-1:0] num_words_i,
    output logic [width_p-1:0]       data_o,
    output logic                     v_o,
    input  logic                     ready_and_i,
    input  logic [width_p-1:0]       data_i,
    input  logic                     v_i,
    output logic                     yumi_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic [count_width_p-1:0] err_cnt_o,
    output logic [count_width_p-1:0] first_err_idx_o,
    output logic [count_width_p-1:0] tx_cnt_o,
    output logic [count_width_p-1:0] rx_cnt_o
);

    localparam int rep_lp     = width_p / 32;
    localparam int timer_w_lp = $clog2(timeout_p + 1);

    localparam logic [count_width_p-1:0] cnt_one_lp    = count_width_p'(1);
    localparam logic [timer_w_lp-1:0]    timer_one_lp  = timer_w_lp'(1);
    // Timer value in the last idle cycle before the abort takes effect.
    localparam logic [timer_w_lp-1:0]    timer_last_lp = timer_w_lp'(timeout_p - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // 32-bit Fibonacci LFSR step.
    function automatic logic [31:0] f_lfsr_next(input logic [31:0] s);
        f_lfsr_next = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    function automatic logic [width_p-1:0] f_rep(input logic [31:0] s);
        f_rep = {rep_lp{s}};
    endfunction

    state_e                   r_state;
    state_e                   w_state_nxt;
    logic [count_width_p-1:0] r_num;
    logic [31:0]              r_tx_lfsr;
    logic [31:0]              r_rx_lfsr;
    logic [width_p-1:0]       r_data;
    logic [count_width_p-1:0] r_tx_cnt;
    logic [count_width_p-1:0] r_rx_cnt;
    logic [count_width_p-1:0] r_err_cnt;
    logic [count_width_p-1:0] r_first_err_idx;
    logic                     r_timeout;
    logic [timer_w_lp-1:0]    r_idle_timer;

    logic                     w_run;
    logic                     w_start;
    logic                     w_tx_hs;
    logic                     w_rx_hs;
    logic                     w_rx_pending;
    logic                     w_mismatch;
    logic                     w_timeout_hit;
    logic [count_width_p-1:0] w_tx_cnt_nxt;
    logic [count_width_p-1:0] w_rx_cnt_nxt;

    assign w_run        = (r_state == S_RUN);
    assign w_start      = start_i && !w_run;
    assign w_rx_pending = w_run && (r_rx_cnt < r_num);
    assign w_tx_hs      = v_o && ready_and_i;
    assign w_rx_hs      = yumi_o;
    assign w_mismatch   = w_rx_hs && (data_i != f_rep(r_rx_lfsr));
    assign w_tx_cnt_nxt = w_tx_hs ? r_tx_cnt + cnt_one_lp : r_tx_cnt;
    assign w_rx_cnt_nxt = w_rx_hs ? r_rx_cnt + cnt_one_lp : r_rx_cnt;
    assign w_timeout_hit = w_rx_pending && !w_rx_hs && (r_idle_timer == timer_last_lp);

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ----------------------------------------------------------- next state
    // Completion looks at the post-handshake counts so done_o rises the cycle
    // right after the last handshake (and num=0 spends exactly one cycle in RUN).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_timeout_hit ||
                         ((w_tx_cnt_nxt == r_num) && (w_rx_cnt_nxt == r_num)))
                         w_state_nxt = S_DONE;
            S_DONE:  if (w_start) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    // v_o depends only on registers; yumi_o is intentionally combinational
    // from v_i so a word is consumed in the cycle it is presented.
    always_comb begin
        busy_o = w_run;
        done_o = (r_state == S_DONE);
        v_o    = w_run && (r_tx_cnt < r_num);
        yumi_o = v_i && w_rx_pending;
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_num           <= '0;
            r_tx_lfsr       <= seed_p;
            r_rx_lfsr       <= seed_p;
            r_data          <= '0;
            r_tx_cnt        <= '0;
            r_rx_cnt        <= '0;
            r_err_cnt       <= '0;
            r_first_err_idx <= '0;
            r_timeout       <= 1'b0;
            r_idle_timer    <= '0;
        end else if (w_start) begin
            r_num           <= num_words_i;
            r_tx_lfsr       <= seed_p;
            r_rx_lfsr       <= seed_p;
            r_data          <= f_rep(seed_p);
            r_tx_cnt        <= '0;
            r_rx_cnt        <= '0;
            r_err_cnt       <= '0;
            r_first_err_idx <= '0;
            r_timeout       <= 1'b0;
            r_idle_timer    <= '0;
        end else begin
            // TX: data_o always shows the LFSR word currently offered, so it
            // holds steady through any stall.
            if (w_tx_hs) begin
                r_tx_lfsr <= f_lfsr_next(r_tx_lfsr);
                r_data    <= f_rep(f_lfsr_next(r_tx_lfsr));
                r_tx_cnt  <= w_tx_cnt_nxt;
            end

            if (w_rx_hs) begin
                r_rx_lfsr <= f_lfsr_next(r_rx_lfsr);
                r_rx_cnt  <= w_rx_cnt_nxt;
            end

            if (w_mismatch) begin
                if (r_err_cnt == '0) r_first_err_idx <= r_rx_cnt;
                if (r_err_cnt != '1) r_err_cnt <= r_err_cnt + cnt_one_lp;
            end

            // Idle timer only runs while an RX word is still owed.
            if (w_rx_hs) begin
                r_idle_timer <= '0;
            end else if (w_rx_pending) begin
                r_idle_timer <= r_idle_timer + timer_one_lp;
            end

            if (w_timeout_hit) r_timeout <= 1'b1;
        end
    end

    assign data_o          = r_data;
    assign timeout_o       = r_timeout;
    assign err_cnt_o       = r_err_cnt;
    assign first_err_idx_o = r_first_err_idx;
    assign tx_cnt_o        = r_tx_cnt;
    assign rx_cnt_o        = r_rx_cnt;

endmodule

// File: tb/tb_bsg_link_pearl_prbs_tester.sv
// ----------------------------------------------------------------------------
// tb_bsg_link_pearl_prbs_tester
//
// Directed bench for bsg_link_pearl_prbs_tester (width 64, timeout 16).
// A per-cycle vector table covers the basic 4-word loopback run; short
// hand-written sequences cover error injection, a randomly stalled 2-deep
// FIFO loopback, RX timeout, num=0 and reset in the middle of a run.
// Inputs change on the falling edge; outputs are sampled 1ns later.
// ----------------------------------------------------------------------------
module tb_bsg_link_pearl_prbs_tester;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        start_i;
    logic [31:0] num_words_i;
    logic [63:0] data_o;
    logic        v_o;
    logic        ready_and_i;
    logic [63:0] data_i;
    logic        v_i;
    logic        yumi_o;
    logic        busy_o;
    logic        done_o;
    logic        timeout_o;
    logic [31:0] err_cnt_o;
    logic [31:0] first_err_idx_o;
    logic [31:0] tx_cnt_o;
    logic [31:0] rx_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    bsg_link_pearl_prbs_tester #(
        .width_p      (64),
        .count_width_p(32),
        .seed_p       (32'h1),
        .timeout_p    (16)
    ) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .num_words_i    (num_words_i),
        .data_o         (data_o),
        .v_o            (v_o),
        .ready_and_i    (ready_and_i),
        .data_i         (data_i),
        .v_i            (v_i),
        .yumi_o         (yumi_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .timeout_o      (timeout_o),
        .err_cnt_o      (err_cnt_o),
        .first_err_idx_o(first_err_idx_o),
        .tx_cnt_o       (tx_cnt_o),
        .rx_cnt_o       (rx_cnt_o)
    );

    typedef struct {
        logic        start;
        logic        ready;
        logic        vin;
        logic [63:0] din;
        logic        exp_v;
        logic        chk_data;
        logic [63:0] exp_data;
        logic        exp_yumi;
        logic        exp_busy;
        logic        exp_done;
        logic [31:0] exp_tx;
        logic [31:0] exp_rx;
    } vec_t;

    vec_t        t1 [6];
    logic [31:0] seq8 [8];

    // FIFO loopback bookkeeping
    logic [63:0] fifo [$];
    logic [31:0] m_tx;
    logic [63:0] prev_data;
    logic        prev_stall;
    int          rstall;
    int          vstall;
    int          n_push;
    int          cyc;
    logic        rdy;
    logic        vv;

    function automatic logic [63:0] rep(input logic [31:0] x);
        rep = {x, x};
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        lfsr_step = {s[30:0], s[31] ^ s[21] ^ s[1] ^ s[0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_t1(input string tag);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_i);
            start_i     = t1[i].start;
            ready_and_i = t1[i].ready;
            v_i         = t1[i].vin;
            data_i      = t1[i].din;
            #1;
            check($sformatf("%s[%0d] v_o", tag, i), 64'(v_o), 64'(t1[i].exp_v));
            if (t1[i].chk_data)
                check($sformatf("%s[%0d] data_o", tag, i), data_o, t1[i].exp_data);
            check($sformatf("%s[%0d] yumi_o", tag, i), 64'(yumi_o), 64'(t1[i].exp_yumi));
            check($sformatf("%s[%0d] busy_o", tag, i), 64'(busy_o), 64'(t1[i].exp_busy));
            check($sformatf("%s[%0d] done_o", tag, i), 64'(done_o), 64'(t1[i].exp_done));
            check($sformatf("%s[%0d] tx_cnt", tag, i), 64'(tx_cnt_o), 64'(t1[i].exp_tx));
            check($sformatf("%s[%0d] rx_cnt", tag, i), 64'(rx_cnt_o), 64'(t1[i].exp_rx));
        end
        check({tag, " err_cnt"}, 64'(err_cnt_o), 64'd0);
        check({tag, " timeout"}, 64'(timeout_o), 64'd0);
        start_i = 1'b0;
        v_i     = 1'b0;
    endtask

    initial begin
        // Hand-computed LFSR sequence from seed 1.
        seq8[0] = 32'h01; seq8[1] = 32'h03; seq8[2] = 32'h06; seq8[3] = 32'h0D;
        seq8[4] = 32'h1B; seq8[5] = 32'h36; seq8[6] = 32'h6D; seq8[7] = 32'hDB;

        //        start ready vin din           v  chk data            yumi busy done tx rx
        t1[0] = '{1'b1, 1'b1, 1'b0, 64'h0,       1'b0, 1'b1, 64'h0,       1'b0, 1'b0, 1'b0, 0, 0};
        t1[1] = '{1'b0, 1'b1, 1'b1, rep(32'h01), 1'b1, 1'b1, rep(32'h01), 1'b1, 1'b1, 1'b0, 0, 0};
        t1[2] = '{1'b0, 1'b1, 1'b1, rep(32'h03), 1'b1, 1'b1, rep(32'h03), 1'b1, 1'b1, 1'b0, 1, 1};
        t1[3] = '{1'b0, 1'b1, 1'b1, rep(32'h06), 1'b1, 1'b1, rep(32'h06), 1'b1, 1'b1, 1'b0, 2, 2};
        t1[4] = '{1'b0, 1'b1, 1'b1, rep(32'h0D), 1'b1, 1'b1, rep(32'h0D), 1'b1, 1'b1, 1'b0, 3, 3};
        // Done: an extra word offered on v_i must not be consumed.
        t1[5] = '{1'b0, 1'b1, 1'b1, rep(32'h1B), 1'b0, 1'b0, 64'h0,       1'b0, 1'b0, 1'b1, 4, 4};

        reset_i     = 1'b1;
        start_i     = 1'b0;
        num_words_i = 32'd4;
        ready_and_i = 1'b0;
        v_i         = 1'b0;
        data_i      = '0;

        // ---------------- reset state
        @(negedge clk_i);
        @(negedge clk_i);
        check("rst v_o",    64'(v_o),    64'd0);
        check("rst data_o", data_o,      64'd0);
        check("rst busy_o", 64'(busy_o), 64'd0);
        check("rst done_o", 64'(done_o), 64'd0);
        check("rst tx_cnt", 64'(tx_cnt_o), 64'd0);
        reset_i = 1'b0;

        // ---------------- 1: basic loopback, num=4
        num_words_i = 32'd4;
        run_t1("t1");

        // ---------------- 2: loopback num=8 with two corrupted RX words
        @(negedge clk_i);
        start_i = 1'b1; num_words_i = 32'd8; ready_and_i = 1'b1; v_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            v_i     = 1'b1;
            data_i  = rep(seq8[i]);
            if (i == 2) data_i[0]  = ~data_i[0];
            if (i == 5) data_i[63] = ~data_i[63];
            #1;
            check($sformatf("t2 yumi[%0d]", i), 64'(yumi_o), 64'd1);
            check($sformatf("t2 data_o[%0d]", i), data_o, rep(seq8[i]));
            if (i == 3) begin
                check("t2 mid err_cnt", 64'(err_cnt_o), 64'd1);
                check("t2 mid first_idx", 64'(first_err_idx_o), 64'd2);
            end
        end
        @(negedge clk_i);
        v_i = 1'b0;
        #1;
        check("t2 done_o",    64'(done_o),          64'd1);
        check("t2 err_cnt",   64'(err_cnt_o),       64'd2);
        check("t2 first_idx", 64'(first_err_idx_o), 64'd2);
        check("t2 timeout",   64'(timeout_o),       64'd0);
        check("t2 rx_cnt",    64'(rx_cnt_o),        64'd8);

        // ---------------- 3: stalled loopback through a 2-deep FIFO, num=1000
        fifo.delete();
        m_tx = 32'h1; prev_stall = 1'b0; prev_data = '0;
        rstall = 0; vstall = 0; n_push = 0;
        @(negedge clk_i);
        start_i = 1'b1; num_words_i = 32'd1000; ready_and_i = 1'b0; v_i = 1'b0;
        for (cyc = 0; cyc < 10000; cyc++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            // 50% random, but never more than 3 stalls in a row so the RX
            // idle gap stays well inside the 16-cycle timeout.
            rdy = (fifo.size() < 2) && (($urandom_range(0, 1) == 1) || (rstall >= 3));
            vv  = (fifo.size() > 0) && (($urandom_range(0, 1) == 1) || (vstall >= 3));
            rstall = rdy ? 0 : rstall + 1;
            vstall = vv  ? 0 : vstall + 1;
            ready_and_i = rdy;
            v_i         = vv;
            data_i      = vv ? fifo[0] : 64'h0;
            #1;
            if (done_o) break;
            if (prev_stall) begin
                check("t3 v_o held",    64'(v_o), 64'd1);
                check("t3 data_o held", data_o,   prev_data);
            end
            if (v_o && ready_and_i) begin
                check($sformatf("t3 tx word %0d", n_push), data_o, rep(m_tx));
                m_tx = lfsr_step(m_tx);
                fifo.push_back(data_o);
                n_push++;
            end
            if (yumi_o) void'(fifo.pop_front());
            prev_stall = v_o && !ready_and_i;
            prev_data  = data_o;
        end
        check("t3 finished in budget", 64'(done_o), 64'd1);
        check("t3 err_cnt",  64'(err_cnt_o), 64'd0);
        check("t3 tx_cnt",   64'(tx_cnt_o),  64'd1000);
        check("t3 rx_cnt",   64'(rx_cnt_o),  64'd1000);
        check("t3 pushed",   64'(n_push),    64'd1000);
        check("t3 fifo empty", 64'(fifo.size()), 64'd0);
        check("t3 timeout",  64'(timeout_o), 64'd0);
        ready_and_i = 1'b0;
        v_i         = 1'b0;

        // ---------------- 4: RX timeout, num=4, v_i held low
        @(negedge clk_i);
        start_i = 1'b1; num_words_i = 32'd4; ready_and_i = 1'b1; v_i = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
            #1;
            if (c == 16) begin
                check("t4 c16 busy_o",  64'(busy_o),    64'd1);
                check("t4 c16 timeout", 64'(timeout_o), 64'd0);
            end
            if (c == 17) begin
                check("t4 timeout_o", 64'(timeout_o), 64'd1);
                check("t4 done_o",    64'(done_o),    64'd1);
                check("t4 rx_cnt",    64'(rx_cnt_o),  64'd0);
                check("t4 tx_cnt",    64'(tx_cnt_o),  64'd4);
                check("t4 v_o",       64'(v_o),       64'd0);
            end
        end

        // ---------------- 5: num=0
        @(negedge clk_i);
        start_i = 1'b1; num_words_i = 32'd0; ready_and_i = 1'b1; v_i = 1'b1; data_i = rep(32'h1);
        #1;
        check("t5 timeout sticky", 64'(timeout_o), 64'd1);
        @(negedge clk_i);
        start_i = 1'b0;
        #1;
        check("t5 busy_o",  64'(busy_o),    64'd1);
        check("t5 v_o run", 64'(v_o),       64'd0);
        check("t5 yumi run", 64'(yumi_o),   64'd0);
        check("t5 timeout cleared", 64'(timeout_o), 64'd0);
        @(negedge clk_i);
        #1;
        check("t5 done_o",  64'(done_o),  64'd1);
        check("t5 busy off", 64'(busy_o), 64'd0);
        check("t5 v_o done", 64'(v_o),    64'd0);
        check("t5 yumi done", 64'(yumi_o), 64'd0);
        v_i = 1'b0;

        // ---------------- 6: reset mid-run, then replay test 1
        @(negedge clk_i);
        start_i = 1'b1; num_words_i = 32'd4; ready_and_i = 1'b1; v_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk_i);
            start_i = 1'b0;
        end
        #1;
        check("t6 pre tx_cnt", 64'(tx_cnt_o), 64'd3);
        v_i     = 1'b1;
        reset_i = 1'b1;
        #1;
        check("t6 rst v_o",    64'(v_o),    64'd0);
        check("t6 rst data_o", data_o,      64'd0);
        check("t6 rst yumi_o", 64'(yumi_o), 64'd0);
        check("t6 rst busy_o", 64'(busy_o), 64'd0);
        check("t6 rst done_o", 64'(done_o), 64'd0);
        check("t6 rst tx_cnt", 64'(tx_cnt_o), 64'd0);
        check("t6 rst rx_cnt", 64'(rx_cnt_o), 64'd0);
        @(negedge clk_i);
        reset_i = 1'b0;
        v_i     = 1'b0;
        run_t1("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
